// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative unsigned 32-bit multiply/divide unit.
// It computes one bit per clock using shift-add multiply and restoring divide.
// While an operation is in flight, busy stalls decode. The unit then issues a
// one-cycle done/reg_write strobe toward the register file write port.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [4:0]       rd_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       rd_out,
  output logic             reg_write
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MULHU = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_REMU  = 2'b11;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg;
  logic [1:0]         op_reg;
  logic [WIDTH-1:0]   a_reg;       // multiplicand
  logic [WIDTH-1:0]   b_reg;       // divisor
  logic [4:0]         rd_reg;
  logic [2*WIDTH-1:0] prod_reg;    // upper half accumulates, lower half holds the multiplier
  logic [WIDTH-1:0]   rem_reg;     // partial remainder (always below the divisor)
  logic [WIDTH-1:0]   quot_reg;    // dividend shifts out the top, quotient shifts in the bottom
  logic [WIDTH-1:0]   result_reg, result_next;
  logic               result_load;

  logic               accept;
  logic               div_by_zero;
  logic               last_iter;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_step;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   rem_step;
  logic [WIDTH-1:0]   quot_step;

  assign accept      = (state_reg == IDLE) && start;
  assign div_by_zero = op[1] && (src_b == '0);
  assign last_iter   = (state_reg == RUN) && (cnt_reg == CNT_W'(WIDTH - 1));

  // One shift-add multiply step: conditionally add the multiplicand into the
  // upper half, then shift the whole product right by one bit.
  assign mul_sum   = {1'b0, prod_reg[2*WIDTH-1:WIDTH]} + (prod_reg[0] ? {1'b0, a_reg} : '0);
  assign prod_step = {mul_sum, prod_reg[WIDTH-1:1]};

  // One restoring divide step. The subtraction is kept only when it does not
  // go negative, so the stored remainder always fits in WIDTH bits.
  assign div_shift = {rem_reg, quot_reg[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, b_reg});
  assign rem_step  = div_ge ? WIDTH'(div_shift - {1'b0, b_reg}) : div_shift[WIDTH-1:0];
  assign quot_step = {quot_reg[WIDTH-2:0], div_ge};

  // Next-state logic and the status outputs that are derived from state.
  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = div_by_zero ? DONE : RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_iter) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Result capture: either the divide-by-zero answer at accept time, or the
  // final value selected from the last iteration's step values.
  always_comb begin
    result_load = 1'b0;
    result_next = result_reg;
    if (accept && div_by_zero) begin
      result_load = 1'b1;
      result_next = (op == OP_DIVU) ? '1 : src_a;
    end else if (last_iter) begin
      result_load = 1'b1;
      case (op_reg)
        OP_MUL:   result_next = prod_step[WIDTH-1:0];
        OP_MULHU: result_next = prod_step[2*WIDTH-1:WIDTH];
        OP_DIVU:  result_next = quot_step;
        OP_REMU:  result_next = rem_step;
        default:  result_next = result_reg;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Operand latching on accept and per-cycle iteration of the accumulators.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg  <= '0;
      op_reg   <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      rd_reg   <= '0;
      prod_reg <= '0;
      rem_reg  <= '0;
      quot_reg <= '0;
    end else if (accept) begin
      cnt_reg  <= '0;
      op_reg   <= op;
      a_reg    <= src_a;
      b_reg    <= src_b;
      rd_reg   <= rd_in;
      prod_reg <= {{WIDTH{1'b0}}, src_b};
      rem_reg  <= '0;
      quot_reg <= src_a;
    end else if (state_reg == RUN) begin
      cnt_reg <= cnt_reg + 1'b1;
      if (op_reg[1]) begin
        rem_reg  <= rem_step;
        quot_reg <= quot_step;
      end else begin
        prod_reg <= prod_step;
      end
    end
  end

  // Result register: holds its value until the next completion or reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_reg <= '0;
    end else if (result_load) begin
      result_reg <= result_next;
    end
  end

  assign result    = result_reg;
  assign rd_out    = rd_reg;
  assign reg_write = done && (rd_reg != 5'd0);

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed-vector bench for muldiv_unit.
// Its expected values are hand-computed, and each comparison prints one line.
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [4:0]  rd_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic        reg_write;

  int checks_cnt;
  int errors_cnt;

  muldiv_unit #(.WIDTH(32), .CNT_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .src_a     (src_a),
    .src_b     (src_b),
    .rd_in     (rd_in),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .rd_out    (rd_out),
    .reg_write (reg_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports every check.
  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end else begin
      $display("ok   %s got=%h", tag, obs);
    end
  endtask

  // Issue one op, wait (bounded) for done, and check the latency and outputs.
  // The latency is counted in posedges after the accept edge.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_res, input int exp_lat);
    int cyc;
    @(negedge clk);
    op = o; src_a = a; src_b = b; rd_in = rd; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check_val({tag, "_done_seen"}, {31'd0, done}, 32'd1);
    check_val({tag, "_latency"}, cyc, exp_lat);
    check_val({tag, "_result"}, result, exp_res);
    check_val({tag, "_rd_out"}, {27'd0, rd_out}, {27'd0, rd});
    check_val({tag, "_reg_write"}, {31'd0, reg_write}, {31'd0, (rd != 5'd0)});
    @(posedge clk);
    #1;
    check_val({tag, "_done_clear"}, {31'd0, done}, 32'd0);
    check_val({tag, "_busy_clear"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int cyc;
    int done_seen;
    checks_cnt = 0;
    errors_cnt = 0;
    rst   = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    src_a = '0;
    src_b = '0;
    rd_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_done", {31'd0, done}, 32'd0);
    check_val("rst_result", result, 32'd0);
    check_val("rst_rd_out", {27'd0, rd_out}, 32'd0);
    check_val("rst_reg_write", {31'd0, reg_write}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    run_op("mul_7x6",      2'b00, 32'd7,          32'd6,          5'd5,  32'd42,         32);
    run_op("mulhu_ffff",   2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd1,  32'hFFFF_FFFE,  32);
    run_op("mul_ffff",     2'b00, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd2,  32'h0000_0001,  32);
    run_op("divu_100_7",   2'b10, 32'd100,        32'd7,          5'd3,  32'd14,         32);
    run_op("remu_100_7",   2'b11, 32'd100,        32'd7,          5'd4,  32'd2,          32);
    run_op("divu_5_9",     2'b10, 32'd5,          32'd9,          5'd6,  32'd0,          32);
    run_op("remu_5_9",     2'b11, 32'd5,          32'd9,          5'd7,  32'd5,          32);
    run_op("divu_by0",     2'b10, 32'd1234,       32'd0,          5'd8,  32'hFFFF_FFFF,  0);
    run_op("remu_by0",     2'b11, 32'd1234,       32'd0,          5'd9,  32'd1234,       0);

    // start during RUN and during DONE must be ignored
    @(negedge clk);
    op = 2'b00; src_a = 32'd3; src_b = 32'd5; rd_in = 5'd7; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    op = 2'b10; src_a = 32'd100; src_b = 32'd7; rd_in = 5'd9; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_val("ign_busy_run", {31'd0, busy}, 32'd1);
    cyc = 11;
    while (!done && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    start = 1'b1;
    check_val("ign_latency", cyc, 32);
    check_val("ign_result", result, 32'd15);
    check_val("ign_rd_out", {27'd0, rd_out}, 32'd7);
    @(posedge clk);
    #1;
    check_val("ign_busy_after_done", {31'd0, busy}, 32'd0);
    check_val("ign_done_after_done", {31'd0, done}, 32'd0);
    check_val("ign_result_hold", result, 32'd15);
    start = 1'b0;
    @(posedge clk);
    #1;
    check_val("ign_still_idle", {31'd0, busy}, 32'd0);

    // reset in the middle of an operation
    @(negedge clk);
    op = 2'b00; src_a = 32'd7; src_b = 32'd6; rd_in = 5'd5; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_val("mid_rst_busy", {31'd0, busy}, 32'd0);
    check_val("mid_rst_done", {31'd0, done}, 32'd0);
    check_val("mid_rst_result", result, 32'd0);
    check_val("mid_rst_rd_out", {27'd0, rd_out}, 32'd0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) done_seen++;
    end
    check_val("mid_rst_no_done", done_seen, 0);
    @(negedge clk);
    rst = 1'b1;
    run_op("post_rst_divu", 2'b10, 32'd100, 32'd7, 5'd3, 32'd14, 32);
    run_op("mul_rd0",       2'b00, 32'd7,   32'd6, 5'd0, 32'd42, 32);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
